// File: rtl/ahb_pkg.sv
// Shared AHB definitions used by the master interface and the arbiter side.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    RESP2 = 3'd4
  } master_state_t;

  // A zero-length command is treated as a single beat.
  function automatic logic [4:0] norm_len(input logic [4:0] len);
    return (len == 5'd0) ? 5'd1 : len;
  endfunction

endpackage

// File: rtl/ahb_master_if_if.sv
// Command-side and AHB-side signal bundle for one bus master.
interface ahb_master_if_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        cmd_lock;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        HBUSREQ;
  logic        HLOCK;
  logic        HGRANT;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_lock, wdata,
    input  HGRANT, HREADY, HRESP, HRDATA,
    output cmd_ready, wdata_pop, rdata, rdata_valid, done, err,
    output HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_lock, wdata,
    output HGRANT, HREADY, HRESP, HRDATA,
    input  cmd_ready, wdata_pop, rdata, rdata_valid, done, err,
    input  HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/ahb_master_if.sv
// AHB master: turns a command into word bursts, handling grant loss and
// two-cycle ERROR/RETRY/SPLIT responses.
module ahb_master_if
  import ahb_pkg::*;
(
  input logic            HCLK,
  input logic            HRESETn,
  ahb_master_if_if.master bus
);

  master_state_t state, state_nxt;
  logic [31:0]   addr_nxt;
  logic [31:0]   dp_addr;
  logic [4:0]    beats_left;
  logic          dp_valid, dp_write;
  logic          lock_r, write_r, first_r;
  hburst_t       burst_r;
  logic          done_p1, err_p1, pop_p1, rvld_p1;
  logic [31:0]   rdata_p1;

  hresp_t        hresp;
  htrans_t       htrans;
  logic          busreq;
  logic          cmd_acc, addr_acc, dp_ok, dp_fail;

  assign hresp    = hresp_t'(bus.HRESP);
  assign cmd_acc  = bus.cmd_valid && (state == IDLE);
  assign addr_acc = (state == XFER) && bus.HREADY;
  assign dp_ok    = dp_valid && bus.HREADY && (hresp == HRESP_OKAY);
  assign dp_fail  = dp_valid && !bus.HREADY && (hresp != HRESP_OKAY);

  always_comb begin
    state_nxt = state;
    htrans    = HTRANS_IDLE;
    busreq    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_acc) state_nxt = REQ;
      end
      REQ: begin
        busreq = 1'b1;
        if (bus.HGRANT && bus.HREADY) state_nxt = XFER;
      end
      XFER: begin
        htrans = first_r ? HTRANS_NONSEQ : HTRANS_SEQ;
        busreq = (beats_left > 5'd1);
        if (dp_fail)
          state_nxt = RESP2;
        else if (bus.HREADY && ((beats_left == 5'd1) || !bus.HGRANT))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        busreq = (beats_left != 5'd0);
        if (dp_fail)
          state_nxt = RESP2;
        else if (!dp_valid || dp_ok)
          state_nxt = (beats_left == 5'd0) ? IDLE : REQ;
      end
      RESP2: begin
        if (bus.HREADY) state_nxt = (hresp == HRESP_ERROR) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      addr_nxt   <= '0;
      beats_left <= '0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      lock_r     <= 1'b0;
      write_r    <= 1'b0;
      first_r    <= 1'b0;
      burst_r    <= HBURST_SINGLE;
      done_p1    <= 1'b0;
      err_p1     <= 1'b0;
      pop_p1     <= 1'b0;
      rvld_p1    <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      pop_p1  <= dp_ok && dp_write;
      rvld_p1 <= dp_ok && !dp_write;

      if (cmd_acc) begin
        addr_nxt   <= bus.cmd_addr & ~32'd3;
        beats_left <= norm_len(bus.cmd_len);
        write_r    <= bus.cmd_write;
        lock_r     <= bus.cmd_lock;
        burst_r    <= (norm_len(bus.cmd_len) == 5'd1) ? HBURST_SINGLE : HBURST_INCR;
      end

      // First address after every (re)grant is NONSEQ.
      if (state == REQ)
        first_r <= 1'b1;
      else if (addr_acc)
        first_r <= 1'b0;

      if (addr_acc) begin
        addr_nxt   <= addr_nxt + 32'd4;
        beats_left <= beats_left - 5'd1;
        dp_write   <= write_r;
      end

      if (addr_acc)
        dp_valid <= 1'b1;
      else if (bus.HREADY)
        dp_valid <= 1'b0;

      if ((state == DRAIN) && (state_nxt == IDLE))
        done_p1 <= 1'b1;

      // An address held during the first response cycle was never accepted,
      // so it is still counted in beats_left; only the failed beat is re-added.
      if ((state == RESP2) && bus.HREADY) begin
        if (hresp == HRESP_ERROR) begin
          done_p1    <= 1'b1;
          err_p1     <= 1'b1;
          beats_left <= '0;
        end else begin
          addr_nxt   <= dp_addr;
          beats_left <= beats_left + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (addr_acc) dp_addr <= addr_nxt;
    if (dp_ok && !dp_write) rdata_p1 <= bus.HRDATA;
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.HBUSREQ     = busreq;
  assign bus.HLOCK       = lock_r && (state != IDLE);
  assign bus.HTRANS      = htrans;
  assign bus.HADDR       = addr_nxt;
  assign bus.HWRITE      = write_r;
  assign bus.HSIZE       = HSIZE_WORD;
  assign bus.HBURST      = burst_r;
  assign bus.HWDATA      = (dp_valid && dp_write) ? bus.wdata : '0;
  assign bus.wdata_pop   = pop_p1;
  assign bus.rdata_valid = rvld_p1;
  assign bus.rdata       = rdata_p1;
  assign bus.done        = done_p1;
  assign bus.err         = err_p1;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if with a scoreboard of expected address
// phases, write data, read data and completions.
module tb_ahb_master_if;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_master_if_if bus ();
  ahb_master_if dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        w;
    logic [2:0]  b;
  } aexp_t;

  aexp_t       exp_a[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  aexp_t       e;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int wexp = 0;

  // Slave-side data-phase tracker and read data generator
  logic        tb_dp_v, tb_dp_w;
  logic [31:0] tb_dp_a;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      tb_dp_v <= 1'b0; tb_dp_w <= 1'b0; tb_dp_a <= '0;
    end else if (bus.HREADY) begin
      tb_dp_v <= (bus.HTRANS != 2'b00);
      tb_dp_a <= bus.HADDR;
      tb_dp_w <= bus.HWRITE;
    end
  assign bus.HRDATA = tb_dp_a ^ 32'hCAFE_0000;

  // Write source: holds the current word until wdata_pop
  logic [31:0] wsrc [0:31];
  logic [4:0]  wptr;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) wptr <= '0;
    else if (bus.wdata_pop) wptr <= wptr + 5'd1;
  assign bus.wdata = wsrc[wptr + {4'd0, bus.wdata_pop}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic push_a(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
    exp_a.push_back('{a, t, w, b});
  endtask

  task automatic push_wd(input int n);
    for (int k = 0; k < n; k++) exp_wd.push_back(wsrc[(wexp + k) % 32]);
    wexp = wexp + n;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [4:0] l, input logic lk);
    chk("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_lock = lk;
    bus.cmd_valid = 1'b1;
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_trans(input logic [1:0] t, input string tag);
    int n = 0;
    while (bus.HTRANS !== t && n < 50) begin cyc(1); n++; end
    chk(tag, (n >= 50), 0);
  endtask

  task automatic wait_done(input string tag);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 100) begin cyc(1); n++; end
    chk(tag, (n >= 100), 0);
  endtask

  // Monitor: compare everything the DUT produces against the scoreboard
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1) begin
      if (bus.HTRANS != 2'b00 && bus.HREADY) begin
        chk("addr_q_nonempty", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          chk("haddr", bus.HADDR, e.a);
          chk("htrans", bus.HTRANS, e.t);
          chk("hwrite", bus.HWRITE, e.w);
          chk("hburst", bus.HBURST, e.b);
          chk("hsize", bus.HSIZE, HSIZE_WORD);
        end
      end
      if (tb_dp_v && tb_dp_w && bus.HREADY && bus.HRESP == 2'b00) begin
        chk("wd_q_nonempty", exp_wd.size() != 0, 1);
        if (exp_wd.size() != 0) chk("hwdata", bus.HWDATA, exp_wd.pop_front());
      end
      if (bus.rdata_valid) begin
        chk("rd_q_nonempty", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rdata", bus.rdata, exp_rd.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_q_nonempty", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) chk("err", bus.err, exp_done.pop_front());
      end
      if (bus.wdata_pop) pop_cnt++;
    end
  end

  // Protocol checks
  assert property (@(posedge HCLK) disable iff (!HRESETn)
                   (bus.HTRANS == 2'b11) |-> ($past(bus.HTRANS) != 2'b00))
    else begin bad++; $error("FAIL seq_after_idle observed=%h", bus.HTRANS); end
  assert property (@(posedge HCLK) disable iff (!HRESETn)
                   (bus.HRESP != 2'b00 && !bus.HREADY && !bus.cmd_ready) |=> (bus.HTRANS == 2'b00))
    else begin bad++; $error("FAIL idle_after_resp observed=%h expected=0", bus.HTRANS); end
  assert property (@(posedge HCLK) disable iff (!HRESETn)
                   bus.cmd_ready |-> !bus.HBUSREQ)
    else begin bad++; $error("FAIL busreq_in_idle observed=1 expected=0"); end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int p0, d0;
    for (int i = 0; i < 32; i++) wsrc[i] = 32'h1000_0000 + i * 32'h0101_0101;
    HRESETn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_len = '0; bus.cmd_lock = 1'b0;
    bus.HGRANT = 1'b1; bus.HREADY = 1'b1; bus.HRESP = 2'b00;

    // Reset values
    cyc(2);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_hbusreq", bus.HBUSREQ, 0);
    chk("rst_hlock", bus.HLOCK, 0);
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_hwrite", bus.HWRITE, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_hburst", bus.HBURST, 0);
    chk("rst_hsize", bus.HSIZE, 3'b010);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_pop", bus.wdata_pop, 0);
    chk("rst_rvld", bus.rdata_valid, 0);
    HRESETn = 1'b1;
    cyc(1);

    // 1: write burst of 4
    push_a(32'h100, HTRANS_NONSEQ, 1, HBURST_INCR);
    push_a(32'h104, HTRANS_SEQ, 1, HBURST_INCR);
    push_a(32'h108, HTRANS_SEQ, 1, HBURST_INCR);
    push_a(32'h10C, HTRANS_SEQ, 1, HBURST_INCR);
    push_wd(4);
    exp_done.push_back(1'b0);
    p0 = pop_cnt;
    issue(1, 32'h100, 5'd4, 0);
    wait_trans(HTRANS_NONSEQ, "t1_wait_nonseq");
    cyc(3);
    chk("t1_last_seq", bus.HTRANS, HTRANS_SEQ);
    chk("t1_last_addr", bus.HADDR, 32'h10C);
    chk("t1_busreq_last", bus.HBUSREQ, 0);
    wait_done("t1_done_timeout");
    chk("t1_pops", pop_cnt - p0, 4);

    // 2: single read, unaligned address, latency
    push_a(32'h200, HTRANS_NONSEQ, 0, HBURST_SINGLE);
    exp_rd.push_back(32'h200 ^ 32'hCAFE_0000);
    exp_done.push_back(1'b0);
    issue(0, 32'h203, 5'd1, 0);
    chk("t2_c1_busreq", bus.HBUSREQ, 1);
    chk("t2_c1_idle", bus.HTRANS, HTRANS_IDLE);
    cyc(1);
    chk("t2_c2_nonseq", bus.HTRANS, HTRANS_NONSEQ);
    chk("t2_c2_addr", bus.HADDR, 32'h200);
    chk("t2_c2_burst", bus.HBURST, HBURST_SINGLE);
    cyc(1);
    chk("t2_c3_idle", bus.HTRANS, HTRANS_IDLE);
    cyc(1);
    chk("t2_c4_done", bus.done, 1);
    cyc(1);

    // 3: grant lost after second address
    push_a(32'h100, HTRANS_NONSEQ, 1, HBURST_INCR);
    push_a(32'h104, HTRANS_SEQ, 1, HBURST_INCR);
    push_a(32'h108, HTRANS_NONSEQ, 1, HBURST_INCR);
    push_a(32'h10C, HTRANS_SEQ, 1, HBURST_INCR);
    push_wd(4);
    exp_done.push_back(1'b0);
    p0 = pop_cnt;
    issue(1, 32'h100, 5'd4, 0);
    wait_trans(HTRANS_NONSEQ, "t3_wait_nonseq");
    cyc(1);
    bus.HGRANT = 1'b0;
    chk("t3_second_addr", bus.HADDR, 32'h104);
    cyc(1);
    chk("t3_drain_idle", bus.HTRANS, HTRANS_IDLE);
    chk("t3_drain_busreq", bus.HBUSREQ, 1);
    cyc(1);
    chk("t3_req_idle", bus.HTRANS, HTRANS_IDLE);
    cyc(2);
    bus.HGRANT = 1'b1;
    wait_trans(HTRANS_NONSEQ, "t3_wait_regrant");
    chk("t3_resume_addr", bus.HADDR, 32'h108);
    wait_done("t3_done_timeout");
    chk("t3_pops", pop_cnt - p0, 4);

    // 4: RETRY on beat 2 of 3 reads
    push_a(32'h10, HTRANS_NONSEQ, 0, HBURST_INCR);
    push_a(32'h14, HTRANS_SEQ, 0, HBURST_INCR);
    push_a(32'h14, HTRANS_NONSEQ, 0, HBURST_INCR);
    push_a(32'h18, HTRANS_SEQ, 0, HBURST_INCR);
    exp_rd.push_back(32'h10 ^ 32'hCAFE_0000);
    exp_rd.push_back(32'h14 ^ 32'hCAFE_0000);
    exp_rd.push_back(32'h18 ^ 32'hCAFE_0000);
    exp_done.push_back(1'b0);
    issue(0, 32'h10, 5'd3, 0);
    wait_trans(HTRANS_NONSEQ, "t4_wait_nonseq");
    cyc(1);
    chk("t4_beat2_addr", bus.HADDR, 32'h14);
    cyc(1);
    chk("t4_beat3_addr", bus.HADDR, 32'h18);
    bus.HREADY = 1'b0; bus.HRESP = 2'b10;
    cyc(1);
    chk("t4_resp2_idle", bus.HTRANS, HTRANS_IDLE);
    bus.HREADY = 1'b1;
    cyc(1);
    bus.HRESP = 2'b00;
    chk("t4_rereq", bus.HBUSREQ, 1);
    wait_trans(HTRANS_NONSEQ, "t4_wait_renonseq");
    chk("t4_resume_addr", bus.HADDR, 32'h14);
    wait_done("t4_done_timeout");

    // 5: ERROR on first write beat of 4, locked
    push_a(32'h300, HTRANS_NONSEQ, 1, HBURST_INCR);
    exp_done.push_back(1'b1);
    p0 = pop_cnt;
    issue(1, 32'h300, 5'd4, 1);
    chk("t5_hlock_req", bus.HLOCK, 1);
    wait_trans(HTRANS_NONSEQ, "t5_wait_nonseq");
    cyc(1);
    bus.HREADY = 1'b0; bus.HRESP = 2'b01;
    cyc(1);
    chk("t5_resp2_idle", bus.HTRANS, HTRANS_IDLE);
    chk("t5_hlock_resp2", bus.HLOCK, 1);
    bus.HREADY = 1'b1;
    cyc(1);
    bus.HRESP = 2'b00;
    chk("t5_done", bus.done, 1);
    chk("t5_err", bus.err, 1);
    chk("t5_busreq", bus.HBUSREQ, 0);
    chk("t5_hlock_after", bus.HLOCK, 0);
    cyc(1);
    chk("t5_pops", pop_cnt - p0, 0);

    // 6: reset in the middle of a burst, then a clean command
    push_a(32'h400, HTRANS_NONSEQ, 1, HBURST_INCR);
    push_a(32'h404, HTRANS_SEQ, 1, HBURST_INCR);
    push_a(32'h408, HTRANS_SEQ, 1, HBURST_INCR);
    push_a(32'h40C, HTRANS_SEQ, 1, HBURST_INCR);
    push_wd(4);
    exp_done.push_back(1'b0);
    issue(1, 32'h400, 5'd4, 0);
    wait_trans(HTRANS_NONSEQ, "t6_wait_nonseq");
    cyc(1);
    d0 = done_cnt;
    #2 HRESETn = 1'b0;
    #1;
    chk("t6_htrans_async", bus.HTRANS, 0);
    chk("t6_busreq_async", bus.HBUSREQ, 0);
    chk("t6_cmd_ready_async", bus.cmd_ready, 1);
    chk("t6_haddr_async", bus.HADDR, 0);
    chk("t6_hwdata_async", bus.HWDATA, 0);
    exp_a.delete(); exp_wd.delete(); exp_rd.delete(); exp_done.delete();
    wexp = 0;
    cyc(2);
    HRESETn = 1'b1;
    cyc(2);
    chk("t6_no_done", done_cnt - d0, 0);
    push_a(32'h500, HTRANS_NONSEQ, 0, HBURST_INCR);
    push_a(32'h504, HTRANS_SEQ, 0, HBURST_INCR);
    exp_rd.push_back(32'h500 ^ 32'hCAFE_0000);
    exp_rd.push_back(32'h504 ^ 32'hCAFE_0000);
    exp_done.push_back(1'b0);
    issue(0, 32'h500, 5'd2, 0);
    wait_done("t6_done_timeout");
    cyc(2);

    chk("end_addr_q_empty", exp_a.size(), 0);
    chk("end_wd_q_empty", exp_wd.size(), 0);
    chk("end_rd_q_empty", exp_rd.size(), 0);
    chk("end_done_q_empty", exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
